buzzer_ctrl: RTL and testbench

Arbiter and sequencer for the single piezo buzzer shared by the pet's event sources. It latches one-cycle beep requests from up to three requesters (microphone wake alert, needs alarm, UI click), grants the buzzer to one at a time by fixed priority, and plays that requester's beep pattern: tone bursts separated by silences, then a guard gap. It sits between the sensor/FSM logic and the buzzer pin, so no other block drives the buzzer directly.

---
 rtl/buzzer_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_buzzer_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_ctrl.sv
// Shared piezo buzzer arbiter: latches one-cycle beep requests, grants by fixed
// priority (bit 0 highest) and plays the owner's burst/silence/gap pattern.
module buzzer_ctrl #(
  parameter int TICK_DIV  = 50,
  parameter int TONE_HALF = 5,
  parameter int ON_TICKS  = 10,
  parameter int OFF_TICKS = 10,
  parameter int GAP_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       en,
  output logic       buzzer,
  output logic [2:0] grant,
  output logic       busy,
  output logic       done
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ?
                             ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
                             ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int CYC_W  = $clog2(TICK_DIV) + 1;
  localparam int TICK_W = $clog2(MAX_TICKS) + 1;
  localparam int TONE_W = $clog2(TONE_HALF) + 1;
  localparam int BEEP_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          pending_q, pending_d;
  logic [2:0]          grant_q, grant_d;
  logic [BEEP_W-1:0]   beeps_q, beeps_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic                tone_q, tone_d;
  logic                buzzer_q, buzzer_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [2:0]          clr_s;
  logic                enter_s;
  logic                phase_end_s;
  logic [TICK_W-1:0]   phase_last_s;

  // Last tick index of the phase currently being timed.
  always_comb begin
    phase_last_s = {TICK_W{1'b0}};
    case (state_q)
      S_ON:    phase_last_s = TICK_W'(ON_TICKS - 1);
      S_OFF:   phase_last_s = TICK_W'(OFF_TICKS - 1);
      S_GAP:   phase_last_s = TICK_W'(GAP_TICKS - 1);
      default: phase_last_s = {TICK_W{1'b0}};
    endcase
  end

  assign phase_end_s = (state_q != S_IDLE) &&
                       (cyc_q == CYC_W'(TICK_DIV - 1)) &&
                       (tick_q == phase_last_s);

  // Next-state, arbitration and output computation.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    beeps_d   = beeps_q;
    done_d    = 1'b0;
    clr_s     = 3'b000;
    enter_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q != 3'b000) begin
          if (pending_q[0]) begin
            grant_d = 3'b001;
            beeps_d = BEEP_W'(3);
          end else if (pending_q[1]) begin
            grant_d = 3'b010;
            beeps_d = BEEP_W'(2);
          end else begin
            grant_d = 3'b100;
            beeps_d = BEEP_W'(1);
          end
          clr_s   = grant_d;
          state_d = S_ON;
          enter_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        if (phase_end_s) begin
          beeps_d = beeps_q - BEEP_W'(1);
          state_d = (beeps_q == BEEP_W'(1)) ? S_GAP : S_OFF;
          enter_s = 1'b1;
        end else begin
          state_d = S_ON;
        end
      end
      S_OFF: begin
        if (phase_end_s) begin
          state_d = S_ON;
          enter_s = 1'b1;
        end else begin
          state_d = S_OFF;
        end
      end
      S_GAP: begin
        if (phase_end_s) begin
          state_d = S_IDLE;
          grant_d = 3'b000;
          done_d  = 1'b1;
          enter_s = 1'b1;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 3'b000;
      end
    endcase

    // A request on the granting edge survives the clear, so it is served again.
    pending_d = (pending_q & ~clr_s) | req;

    if (enter_s || (state_d == S_IDLE)) begin
      cyc_d  = {CYC_W{1'b0}};
      tick_d = {TICK_W{1'b0}};
    end else if (cyc_q == CYC_W'(TICK_DIV - 1)) begin
      cyc_d  = {CYC_W{1'b0}};
      tick_d = tick_q + TICK_W'(1);
    end else begin
      cyc_d  = cyc_q + CYC_W'(1);
      tick_d = tick_q;
    end

    if (state_d != S_ON) begin
      tone_d     = 1'b0;
      tone_cnt_d = {TONE_W{1'b0}};
    end else if (enter_s) begin
      tone_d     = 1'b1;
      tone_cnt_d = {TONE_W{1'b0}};
    end else if (tone_cnt_q == TONE_W'(TONE_HALF - 1)) begin
      tone_d     = ~tone_q;
      tone_cnt_d = {TONE_W{1'b0}};
    end else begin
      tone_d     = tone_q;
      tone_cnt_d = tone_cnt_q + TONE_W'(1);
    end

    buzzer_d = (state_d == S_ON) & tone_d & en;
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any pattern in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pending_q  <= 3'b000;
      grant_q    <= 3'b000;
      beeps_q    <= {BEEP_W{1'b0}};
      cyc_q      <= {CYC_W{1'b0}};
      tick_q     <= {TICK_W{1'b0}};
      tone_cnt_q <= {TONE_W{1'b0}};
      tone_q     <= 1'b0;
      buzzer_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      beeps_q    <= beeps_d;
      cyc_q      <= cyc_d;
      tick_q     <= tick_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      buzzer_q   <= buzzer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign buzzer = buzzer_q;
  assign grant  = grant_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_buzzer_ctrl.sv
// Bench for buzzer_ctrl: a timeline model (cycles since grant) checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_buzzer_ctrl;

  localparam int ON_CYC  = 500;
  localparam int GAP_CYC = 1000;
  localparam int HALF    = 5;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic       en;
  logic       buzzer;
  logic [2:0] grant;
  logic       busy;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;
  logic chk_on = 1'b0;

  // model state: owner, beeps, cycles since grant
  logic [2:0] m_pend, m_own;
  int         m_b, m_t;
  logic       m_done, m_en;

  int len, hi;

  buzzer_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .en     (en),
    .buzzer (buzzer),
    .grant  (grant),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pat_len(int b);
    return (2 * b - 1) * ON_CYC + GAP_CYC;
  endfunction

  function automatic logic exp_buzz();
    if (m_own == 3'b000) return 1'b0;
    if (m_t >= (2 * m_b - 1) * ON_CYC) return 1'b0;
    if (((m_t / ON_CYC) % 2) != 0) return 1'b0;
    return (((m_t % ON_CYC) / HALF) % 2 == 0) && m_en;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    logic [2:0] p, own;
    int b, t;
    logic dn;
    if (!rst) begin
      m_pend <= 3'b000; m_own <= 3'b000; m_b <= 0; m_t <= 0;
      m_done <= 1'b0;   m_en <= 1'b0;
    end else begin
      p = m_pend; own = m_own; b = m_b; t = m_t; dn = 1'b0;
      if (own == 3'b000) begin
        if (p[0])      begin own = 3'b001; b = 3; p[0] = 1'b0; end
        else if (p[1]) begin own = 3'b010; b = 2; p[1] = 1'b0; end
        else if (p[2]) begin own = 3'b100; b = 1; p[2] = 1'b0; end
        t = 0;
      end else begin
        t = t + 1;
        if (t == pat_len(b)) begin own = 3'b000; dn = 1'b1; end
      end
      m_pend <= p | req;
      m_own  <= own;
      m_b    <= b;
      m_t    <= t;
      m_done <= dn;
      m_en   <= en;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_total = n_total + 1;
      if ({buzzer, grant, busy, done} ===
          {exp_buzz(), m_own, (m_own != 3'b000), m_done}) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL cycle_model t=%0t buzzer/grant/busy/done got %b/%b/%b/%b want %b/%b/%b/%b",
                 $time, buzzer, grant, busy, done,
                 exp_buzz(), m_own, (m_own != 3'b000), m_done);
      end
    end
  end

  task automatic check(string name, int act, int exp);
    n_total = n_total + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s got %0d want %0d", name, act, exp);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(logic [2:0] r);
    req = r;
    @(negedge clk);
    req = 3'b000;
  endtask

  task automatic count_cycles(int n);
    repeat (n) begin
      len = len + 1;
      hi  = hi + int'(buzzer);
      @(negedge clk);
    end
  endtask

  task automatic count_busy(int bound);
    while (busy && len < bound) begin
      len = len + 1;
      hi  = hi + int'(buzzer);
      @(negedge clk);
    end
    if (busy) $display("FAIL busy_timeout still busy after %0d cycles want idle", len);
  endtask

  initial begin
    rst = 1'b0; req = 3'b000; en = 1'b1;
    tick(3);
    chk_on = 1'b1;
    check("reset_outputs", int'({buzzer, grant, busy, done}), 0);
    rst = 1'b1;
    tick(3);

    // single UI click
    pulse(3'b100);
    check("latency_pending_only", int'(grant), 0);
    tick(1);
    check("latency_on", int'({grant, busy, buzzer}), 5'b100_1_1);
    len = 0; hi = 0;
    count_busy(5000);
    check("busy_len_1beep", len, 1500);
    check("tone_high_1beep", hi, 250);
    check("done_pulse_1beep", int'({done, grant}), 4'b1_000);
    tick(5);

    // mic wake, three beeps
    pulse(3'b001);
    tick(1);
    len = 0; hi = 0;
    count_busy(5000);
    check("busy_len_3beep", len, 3500);
    check("tone_high_3beep", hi, 750);
    tick(5);

    // simultaneous requests: priority then follow-on grant
    pulse(3'b101);
    tick(1);
    check("prio_grant_first", int'(grant), 3'b001);
    len = 0; hi = 0;
    count_busy(5000);
    check("prio_len_first", len, 3500);
    tick(1);
    check("prio_grant_second", int'({grant, busy}), 4'b100_1);
    len = 0; hi = 0;
    count_busy(5000);
    check("prio_len_second", len, 1500);
    tick(5);

    // needs alarm arriving mid-pattern waits
    pulse(3'b100);
    tick(1);
    tick(200);
    pulse(3'b010);
    check("no_preempt", int'(grant), 3'b100);
    len = 0; hi = 0;
    count_busy(5000);
    tick(1);
    check("deferred_grant", int'(grant), 3'b010);
    len = 0; hi = 0;
    count_busy(5000);
    check("busy_len_2beep", len, 2500);
    check("tone_high_2beep", hi, 500);
    tick(5);

    // mute during second burst
    pulse(3'b001);
    tick(1);
    len = 0; hi = 0;
    count_cycles(1100);
    en = 1'b0;
    count_cycles(200);
    en = 1'b1;
    count_busy(5000);
    check("mute_len", len, 3500);
    check("mute_tone_high", hi, 650);
    tick(5);

    // reset mid-burst with another request pending
    pulse(3'b001);
    tick(101);
    pulse(3'b010);
    tick(10);
    #2 rst = 1'b0;
    #1 check("reset_mid_on", int'({buzzer, grant, busy, done}), 0);
    @(negedge clk);
    rst = 1'b1;
    len = 0; hi = 0;
    repeat (3000) begin
      hi  = hi + int'(buzzer);
      len = len + int'(busy);
      @(negedge clk);
    end
    check("post_reset_quiet_buzz", hi, 0);
    check("post_reset_quiet_busy", len, 0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
